// File: rtl/vender_ctrl.sv
// Coin vender transaction controller: collects J/Y coin credit against PRICE,
// runs the dispense req/ack handshake, then pays change in 5-unit pulses.
module vender_ctrl #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 40,
  parameter int CREDIT_W   = 6,
  parameter int TIMEOUT    = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                J,
  input  logic                Y,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                open,
  output logic                change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          dbg_state
);

  // Handshake: open is a level request held from VEND entry until the cycle
  // disp_ack is sampled high; disp_ack is a one-cycle done strobe.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_RETURN  = 2'd3
  } state_e;

  localparam int CW1   = CREDIT_W + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] FIVE_C   = CREDIT_W'(5);
  localparam logic [CW1-1:0]      PRICE_W  = CW1'(PRICE);
  localparam logic [CW1-1:0]      MAX_W    = CW1'(MAX_CREDIT);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                reject_q, reject_d;

  logic                coin_any;
  logic                coin_ok;
  logic [CW1-1:0]      coin_val;
  logic [CW1-1:0]      coin_sum;
  logic [CREDIT_W-1:0] credit_new;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      timer_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      timer_q  <= timer_d;
      reject_q <= reject_d;
    end
  end

  // Ceiling is checked on the widened sum so a large coin can never wrap.
  always_comb begin
    coin_any   = J | Y;
    coin_val   = CW1'(J ? 5 : 0) + CW1'(Y ? 10 : 0);
    coin_sum   = {1'b0, credit_q} + coin_val;
    coin_ok    = coin_any && (coin_sum <= MAX_W);
    credit_new = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    timer_d  = '0;
    reject_d = coin_any;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        reject_d = coin_any && !coin_ok;
        credit_d = credit_new;
        if (cancel && (credit_new != '0)) begin
          state_d = S_RETURN;
        end else if ({1'b0, credit_new} >= PRICE_W) begin
          state_d = S_VEND;
        end else if ((state_q == S_COLLECT) && !coin_ok && (timer_q == TMR_LAST)) begin
          state_d = S_RETURN;
        end else if (credit_new != '0) begin
          state_d = S_COLLECT;
          // The count restarts on COLLECT entry and on every accepted coin.
          if ((state_q == S_COLLECT) && !coin_ok) timer_d = timer_q + TMR_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VEND: begin
        if (disp_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_q != PRICE_C) ? S_RETURN : S_IDLE;
        end
      end
      S_RETURN: begin
        if (credit_q <= FIVE_C) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end else begin
          credit_d = credit_q - FIVE_C;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  assign open        = (state_q == S_VEND);
  assign change      = (state_q == S_RETURN);
  assign busy        = (state_q == S_VEND) || (state_q == S_RETURN);
  assign coin_reject = reject_q;
  assign credit      = credit_q;
  assign dbg_state   = state_q;

endmodule
